fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
- Parametrised single-clock synchronous FIFO; next generation of the team's fixed 16-bit FIFO.
- Generalised in data width and depth, with programmable almost-full/almost-empty thresholds.
- Adds an occupancy count output and a read-valid strobe.
- Serves as the common buffering block between SPI front-end and RAM back-end, and anywhere else a same-clock queue is needed.

Parameters:
- DATA_W, 16, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2; power of two not required).
- AFULL_TH, DEPTH-1, almostfull asserts when count >= AFULL_TH and count < DEPTH (1 <= AFULL_TH <= DEPTH-1).
- AEMPTY_TH, 1, almostempty asserts when count > 0 and count <= AEMPTY_TH (1 <= AEMPTY_TH <= DEPTH-1).

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- data_in, input, DATA_W, write data.
- wr_en, input, 1, write request.
- rd_en, input, 1, read request.
- data_out, output, DATA_W, registered read data.
- rd_valid, output, 1, data_out updated this cycle.
- wr_ack, output, 1, previous-cycle write accepted.
- overflow, output, 1, previous-cycle write rejected (full).
- underflow, output, 1, previous-cycle read rejected (empty).
- full, output, 1, count == DEPTH.
- almostfull, output, 1, AFULL_TH <= count < DEPTH.
- empty, output, 1, count == 0.
- almostempty, output, 1, 0 < count <= AEMPTY_TH.
- count, output, $clog2(DEPTH+1), current occupancy.

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset (async assert, any time, mid-operation included):
  - wr_ptr, rd_ptr, count = 0; data_out = 0.
  - rd_valid, wr_ack, overflow, underflow = 0.
  - Hence empty = 1, all other flags 0.
  - Memory contents are not cleared; they are don't-care.
- Accept rules, evaluated on pre-edge state:
  - wr_acc = wr_en && !full.
  - rd_acc = rd_en && !empty.
  - Full plus simultaneous rd_en/wr_en: read accepted, write rejected (overflow).
  - Empty plus simultaneous: write accepted, read rejected (underflow).
- Write: mem[wr_ptr] <= data_in; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Read: data_out <= mem[rd_ptr] at the same edge, i.e. 1-cycle read latency. rd_ptr wraps DEPTH-1 -> 0. data_out holds its value when no read is accepted.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Registered strobes, each high exactly one cycle after the causing edge:
  - rd_valid <= rd_acc.
  - wr_ack <= wr_acc.
  - overflow <= wr_en && !wr_acc.
  - underflow <= rd_en && !rd_acc.
- full, almostfull, empty, almostempty are combinational decodes of registered count. No extra latency; glitch-free because count is a register.
- Simultaneous accepted read and write at the same address (count 0 is impossible since the read is rejected; count == DEPTH only happens when full) never occur together. No bypass path is required.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- With it defined:
  - Extra input err_clr (1 bit, synchronous).
  - Extra output err_sticky (2 bits): [1] overflow seen, [0] underflow seen.
  - Bits set on the same edge that overflow/underflow is registered.
  - Cleared by err_clr; a set in the same cycle wins over the clear.
  - Reset to 0.
- Without it: ports absent; no sticky logic.

Decomposition:
- Package fifo_pkg holds:
  - Default constants: FIFO_DATA_W_DEF = 16, FIFO_DEPTH_DEF = 8.
  - Function cnt_w(depth) returning $clog2(depth+1).
  - Typedef for the 2-bit sticky-error vector.
- One natural sub-module: fifo_mem.
  - Simple dual-port array, DATA_W x DEPTH.
  - Write port with en/addr/data; synchronous read port with en/addr giving registered data.
  - Instantiated once; pointer/count/flag control stays in fifo_sync_param.

Test Plan:
- Reset then fill: defaults, write 8 words 0x0001..0x0008 with no reads.
  - wr_ack after each; count 1..8.
  - almostfull only at count 7; full at count 8.
  - 9th write -> overflow = 1 next cycle, count stays 8.
- Drain and order: from full, rd_en for 9 cycles.
  - data_out = 0x0001..0x0008, each with rd_valid 1 cycle after rd_en.
  - almostempty at count 1; empty at 0.
  - 9th read -> underflow, data_out holds 0x0008.
- Simultaneous at boundaries:
  - Full + wr_en + rd_en -> read only, count 8 -> 7, overflow = 1.
  - Empty + both -> write only, count 0 -> 1, underflow = 1.
  - count 4 + both -> count stays 4, wr_ack and rd_valid both high.
- Wrap-around and non-power-of-two: DEPTH = 5, DATA_W = 8, 20 interleaved writes/reads with data 0x00..0x13.
  - Output order preserved; count never exceeds 5.
- Thresholds and reset: DEPTH = 16, AFULL_TH = 12, AEMPTY_TH = 4.
  - almostempty for counts 1..4; almostfull for counts 12..15.
  - Assert rst asynchronously at count 10, mid-clock -> count = 0, empty = 1 immediately, all strobes 0.
- FIFO_STICKY_ERR_EN build: force overflow then underflow -> err_sticky = 2'b11 and holds; err_clr pulse -> 2'b00; err_clr coincident with a new underflow -> 2'b01.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared defaults, count-width helper and sticky-error type
//                for the parametrised synchronous FIFO.
//  Revision    : 1.0
// ============================================================================
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 16;
    localparam int FIFO_DEPTH_DEF  = 8;

    // [1] overflow seen, [0] underflow seen
    typedef logic [1:0] err_vec_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : Simple dual-port storage array, DATA_W x DEPTH, with one
//                write port and one registered synchronous read port.
//  Revision    : 1.0
// ============================================================================
module fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync_param
//  Description : Parametrised single-clock FIFO with occupancy count,
//                programmable almost-full/almost-empty and 1-cycle strobes.
//                Optional sticky error flags when FIFO_STICKY_ERR_EN is defined.
//  Revision    : 1.0
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int AFULL_TH  = DEPTH - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef FIFO_STICKY_ERR_EN
    input  logic                       err_clr,
    output err_vec_t                   err_sticky,
`endif
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       rd_valid,
    output logic                       wr_ack,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       full,
    output logic                       almostfull,
    output logic                       empty,
    output logic                       almostempty,
    output logic [cnt_w(DEPTH)-1:0]    count
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rd_valid_q, wr_ack_q, overflow_q, underflow_q;
    logic             wr_acc, rd_acc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_acc;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && !wr_acc;
            underflow_q <= rd_en && !rd_acc;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (data_in),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (data_out)
    );

`ifdef FIFO_STICKY_ERR_EN
    err_vec_t err_q, err_d;

    // A new error in the same cycle as err_clr must survive the clear.
    always_comb begin
        err_d = err_clr ? err_vec_t'(2'b00) : err_q;
        err_d = err_d | {wr_en && !wr_acc, rd_en && !rd_acc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;
`endif

    // Flags decode the registered count, so they cannot glitch.
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almostfull  = (count_q >= CNT_W'(AFULL_TH)) && !full;
    assign empty       = (count_q == '0);
    assign almostempty = !empty && (count_q <= CNT_W'(AEMPTY_TH));

    assign rd_valid  = rd_valid_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;

endmodule : fifo_sync_param
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_sync_param
//  Description : Scoreboard bench for fifo_sync_param: default 8x16, a 5x8
//                wrap-around instance and a 16-deep threshold instance.
//                Sticky checks are compiled in with FIFO_STICKY_ERR_EN.
//  Revision    : 1.0
// ============================================================================
module tb_fifo_sync_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Shared reference model: instances are exercised one phase at a time.
    logic [15:0] exp_q[$];
    int          m_cnt  = 0;
    logic [15:0] m_last = '0;

    // ---------------- instance A: defaults ----------------
    logic        a_rst = 1'b1, a_wr = 1'b0, a_rd = 1'b0;
    logic [15:0] a_din = '0, a_dout;
    logic        a_rv, a_ack, a_ovf, a_udf, a_full, a_af, a_empty, a_ae;
    logic [3:0]  a_cnt;
`ifdef FIFO_STICKY_ERR_EN
    logic        a_clr = 1'b0;
    logic [1:0]  a_err;
`endif

    fifo_sync_param u_a (
        .clk (clk), .rst (a_rst),
`ifdef FIFO_STICKY_ERR_EN
        .err_clr (a_clr), .err_sticky (a_err),
`endif
        .data_in (a_din), .wr_en (a_wr), .rd_en (a_rd), .data_out (a_dout),
        .rd_valid (a_rv), .wr_ack (a_ack), .overflow (a_ovf), .underflow (a_udf),
        .full (a_full), .almostfull (a_af), .empty (a_empty),
        .almostempty (a_ae), .count (a_cnt)
    );

    // ---------------- instance B: DEPTH 5, DATA_W 8 ----------------
    logic        b_rst = 1'b1, b_wr = 1'b0, b_rd = 1'b0;
    logic [7:0]  b_din = '0, b_dout;
    logic        b_rv, b_ack, b_ovf, b_udf, b_full, b_af, b_empty, b_ae;
    logic [2:0]  b_cnt;
`ifdef FIFO_STICKY_ERR_EN
    logic        b_clr = 1'b0;
    logic [1:0]  b_err;
`endif

    fifo_sync_param #(.DATA_W(8), .DEPTH(5)) u_b (
        .clk (clk), .rst (b_rst),
`ifdef FIFO_STICKY_ERR_EN
        .err_clr (b_clr), .err_sticky (b_err),
`endif
        .data_in (b_din), .wr_en (b_wr), .rd_en (b_rd), .data_out (b_dout),
        .rd_valid (b_rv), .wr_ack (b_ack), .overflow (b_ovf), .underflow (b_udf),
        .full (b_full), .almostfull (b_af), .empty (b_empty),
        .almostempty (b_ae), .count (b_cnt)
    );

    // ---------------- instance C: DEPTH 16, thresholds 12/4 ----------------
    logic        c_rst = 1'b1, c_wr = 1'b0, c_rd = 1'b0;
    logic [15:0] c_din = '0, c_dout;
    logic        c_rv, c_ack, c_ovf, c_udf, c_full, c_af, c_empty, c_ae;
    logic [4:0]  c_cnt;
`ifdef FIFO_STICKY_ERR_EN
    logic        c_clr = 1'b0;
    logic [1:0]  c_err;
`endif

    fifo_sync_param #(.DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4)) u_c (
        .clk (clk), .rst (c_rst),
`ifdef FIFO_STICKY_ERR_EN
        .err_clr (c_clr), .err_sticky (c_err),
`endif
        .data_in (c_din), .wr_en (c_wr), .rd_en (c_rd), .data_out (c_dout),
        .rd_valid (c_rv), .wr_ack (c_ack), .overflow (c_ovf), .underflow (c_udf),
        .full (c_full), .almostfull (c_af), .empty (c_empty),
        .almostempty (c_ae), .count (c_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called #1 after the edge; m_cnt still holds the pre-edge occupancy.
    task automatic score(input string tag, input int depth, input int af, input int ae,
                         input bit wr, input bit rd, input logic [15:0] d,
                         input logic [15:0] o_dout, input bit o_rv, input bit o_ack,
                         input bit o_ovf, input bit o_udf, input bit o_full,
                         input bit o_af, input bit o_empty, input bit o_ae, input int o_cnt);
        bit wacc, racc;
        wacc = wr && (m_cnt < depth);
        racc = rd && (m_cnt > 0);
        if (wacc) exp_q.push_back(d);
        if (racc) m_last = exp_q.pop_front();
        m_cnt = m_cnt + int'(wacc) - int'(racc);
        check({tag, ".rd_valid"},   32'(o_rv),    32'(racc));
        check({tag, ".wr_ack"},     32'(o_ack),   32'(wacc));
        check({tag, ".overflow"},   32'(o_ovf),   32'(wr && !wacc));
        check({tag, ".underflow"},  32'(o_udf),   32'(rd && !racc));
        check({tag, ".data_out"},   32'(o_dout),  32'(m_last));
        check({tag, ".count"},      32'(o_cnt),   32'(m_cnt));
        check({tag, ".full"},       32'(o_full),  32'(m_cnt == depth));
        check({tag, ".almostfull"}, 32'(o_af),    32'((m_cnt >= af) && (m_cnt < depth)));
        check({tag, ".empty"},      32'(o_empty), 32'(m_cnt == 0));
        check({tag, ".almostempty"},32'(o_ae),    32'((m_cnt > 0) && (m_cnt <= ae)));
    endtask

    task automatic step_a(input bit wr, input bit rd, input logic [15:0] d);
        a_wr = wr; a_rd = rd; a_din = d;
        @(posedge clk); #1;
        a_wr = 1'b0; a_rd = 1'b0;
        score("A", 8, 7, 1, wr, rd, d, a_dout, a_rv, a_ack, a_ovf, a_udf,
              a_full, a_af, a_empty, a_ae, int'(a_cnt));
    endtask

    task automatic step_b(input bit wr, input bit rd, input logic [7:0] d);
        b_wr = wr; b_rd = rd; b_din = d;
        @(posedge clk); #1;
        b_wr = 1'b0; b_rd = 1'b0;
        score("B", 5, 4, 1, wr, rd, {8'h00, d}, {8'h00, b_dout}, b_rv, b_ack, b_ovf,
              b_udf, b_full, b_af, b_empty, b_ae, int'(b_cnt));
    endtask

    task automatic step_c(input bit wr, input bit rd, input logic [15:0] d);
        c_wr = wr; c_rd = rd; c_din = d;
        @(posedge clk); #1;
        c_wr = 1'b0; c_rd = 1'b0;
        score("C", 16, 12, 4, wr, rd, d, c_dout, c_rv, c_ack, c_ovf, c_udf,
              c_full, c_af, c_empty, c_ae, int'(c_cnt));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt  = 0;
        m_last = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr;
        int cyc;
        bit w, r, acc;

        repeat (2) @(posedge clk);
        #1;
        check("A.rst.empty",    32'(a_empty), 32'd1);
        check("A.rst.count",    32'(a_cnt),   32'd0);
        check("A.rst.data_out", 32'(a_dout),  32'd0);
        check("A.rst.flags",    {a_rv, a_ack, a_ovf, a_udf, a_full, a_af, a_ae}, 32'd0);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // Fill, then one write too many.
        model_reset();
        for (int i = 1; i <= 9; i++) step_a(1'b1, 1'b0, 16'(i));
        // Drain in order, then one read too many.
        for (int i = 0; i < 9; i++) step_a(1'b0, 1'b1, 16'h0);
        check("A.drain.hold", 32'(a_dout), 32'h0008);

`ifdef FIFO_STICKY_ERR_EN
        check("A.sticky.both", 32'(a_err), 32'b11);
        step_a(1'b0, 1'b0, 16'h0);
        check("A.sticky.hold", 32'(a_err), 32'b11);
        a_clr = 1'b1;
        step_a(1'b0, 1'b0, 16'h0);
        a_clr = 1'b0;
        check("A.sticky.clr", 32'(a_err), 32'b00);
        a_clr = 1'b1;
        step_a(1'b0, 1'b1, 16'h0);
        a_clr = 1'b0;
        check("A.sticky.setwins", 32'(a_err), 32'b01);
`endif

        // Simultaneous requests at the boundaries and mid-range.
        step_a(1'b1, 1'b1, 16'h0055);
        for (int i = 0; i < 7; i++) step_a(1'b1, 1'b0, 16'h0100 + 16'(i));
        step_a(1'b1, 1'b1, 16'h0066);
        check("A.full_both.count", 32'(a_cnt), 32'd7);
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 16'h0);
        step_a(1'b1, 1'b1, 16'h0077);
        check("A.mid_both.strobes", {a_ack, a_rv}, 32'b11);
        while (m_cnt > 0) step_a(1'b0, 1'b1, 16'h0);

        // DEPTH 5 wrap-around with bursty reads.
        model_reset();
        nwr = 0;
        cyc = 0;
        while ((nwr < 20 || exp_q.size() != 0) && cyc < 200) begin
            w   = (nwr < 20);
            r   = (cyc >= 12) || (cyc % 4 == 3);
            acc = w && (m_cnt < 5);
            step_b(w, r, 8'(nwr));
            check("B.count_max", 32'(b_cnt > 3'd5), 32'd0);
            if (acc) nwr++;
            cyc++;
        end
        check("B.all_written", 32'(nwr), 32'd20);
        check("B.all_read",    32'(exp_q.size()), 32'd0);
        check("B.last_word",   32'(b_dout), 32'h13);

        // Thresholds, then async reset at count 10 between edges.
        model_reset();
        for (int i = 0; i < 10; i++) step_c(1'b1, 1'b0, 16'h0A00 + 16'(i));
        #2;
        c_rst = 1'b1;
        #1;
        check("C.arst.count",   32'(c_cnt),   32'd0);
        check("C.arst.empty",   32'(c_empty), 32'd1);
        check("C.arst.strobes", {c_rv, c_ack, c_ovf, c_udf}, 32'd0);
        check("C.arst.flags",   {c_full, c_af, c_ae}, 32'd0);
        #2;
        c_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) step_c(1'b1, 1'b0, 16'h0C00 + 16'(i));
        while (m_cnt > 0) step_c(1'b0, 1'b1, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fifo_sync_param
`default_nettype wire
